// File: rtl/ssd_scan_decoder.sv
// Seven-segment scan monitor: rebuilds the 16-bit value shown on a multiplexed display.
// Define SSD_SCAN_CONFIRM_EN to publish only frames that repeat the previous frame.
module ssd_scan_decoder #(
    parameter int SETTLE = 4,
    parameter int TO_W   = 20
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [3:0]  Anode,
    input  logic [6:0]  LED_out,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        digit_err,
    output logic        blank
);
    localparam logic [3:0]      CNT_HIT = 4'(SETTLE - 1);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    logic [3:0]      r_an;
    logic [3:0]      r_an_d;
    logic [6:0]      r_seg;
    logic [6:0]      r_seg_d;
    logic [3:0]      r_cnt;
    logic [3:0]      r_mask;
    logic [3:0]      r_serr;
    logic [15:0]     r_slot;
    logic [TO_W-1:0] r_to;
    logic [15:0]     r_value;
    logic            r_vv;
    logic            r_err;

    logic            w_valid;
    logic [1:0]      w_idx;
    logic [3:0]      w_nib;
    logic            w_bad;
    logic            w_same;
    logic            w_cap;
    logic            w_full;
    logic            w_tmo;
    logic            w_pub;
    logic            w_any_err;
    logic [3:0]      w_bit;
    logic [3:0]      w_mask_nx;
    logic [3:0]      w_serr_nx;

    always_comb begin
        w_valid = 1'b1;
        w_idx   = 2'd0;
        case (r_an)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_nib = 4'h0;
        w_bad = 1'b0;
        case (r_seg)
            7'b0000001: w_nib = 4'h0;
            7'b1001111: w_nib = 4'h1;
            7'b0010010: w_nib = 4'h2;
            7'b0000110: w_nib = 4'h3;
            7'b1001100: w_nib = 4'h4;
            7'b0100100: w_nib = 4'h5;
            7'b0100000: w_nib = 4'h6;
            7'b0001111: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0000100: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b1100000: w_nib = 4'hB;
            7'b0110001: w_nib = 4'hC;
            7'b1000010: w_nib = 4'hD;
            7'b0110000: w_nib = 4'hE;
            7'b0111000: w_nib = 4'hF;
            default:    w_bad = 1'b1;
        endcase
    end

    // Capture exactly once per visit: only when the run length steps onto SETTLE.
    assign w_same    = (r_an == r_an_d) && (r_seg == r_seg_d);
    assign w_cap     = w_valid && w_same && (r_cnt == CNT_HIT);
    assign w_full    = (r_mask == 4'hF);
    assign w_tmo     = (r_to == TO_MAX);
    assign w_any_err = |r_serr;
    assign w_bit     = 4'b0001 << w_idx;

    always_comb begin
        w_mask_nx = r_mask;
        w_serr_nx = r_serr;
        if (w_full || (w_tmo && !w_cap)) begin
            w_mask_nx = 4'h0;
            w_serr_nx = 4'h0;
        end
        if (w_cap) begin
            w_mask_nx = w_mask_nx | w_bit;
            w_serr_nx = w_bad ? (w_serr_nx | w_bit) : (w_serr_nx & ~w_bit);
        end
    end

`ifdef SSD_SCAN_CONFIRM_EN
    logic [16:0] r_cmp;
    logic        r_cmp_v;

    assign w_pub = w_full && r_cmp_v && (r_cmp == {w_any_err, r_slot});

    always_ff @(posedge clk) begin
        if (rest) begin
            r_cmp   <= '0;
            r_cmp_v <= 1'b0;
        end else if (w_full) begin
            r_cmp   <= {w_any_err, r_slot};
            r_cmp_v <= 1'b1;
        end else if (w_tmo && !w_cap) begin
            r_cmp   <= '0;
            r_cmp_v <= 1'b0;
        end
    end
`else
    assign w_pub = w_full;
`endif

    always_ff @(posedge clk) begin
        if (rest) begin
            r_an    <= '0;
            r_an_d  <= '0;
            r_seg   <= '0;
            r_seg_d <= '0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_serr  <= '0;
            r_slot  <= '0;
            r_to    <= '0;
            r_value <= '0;
            r_vv    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_an    <= Anode;
            r_seg   <= LED_out;
            r_an_d  <= r_an;
            r_seg_d <= r_seg;
            if (!w_valid)
                r_cnt <= 4'd0;
            else if (!w_same)
                r_cnt <= 4'd1;
            else if (r_cnt != 4'hF)
                r_cnt <= r_cnt + 4'd1;
            r_mask <= w_mask_nx;
            r_serr <= w_serr_nx;
            if (w_cap)
                r_slot[{w_idx, 2'b00} +: 4] <= w_nib;
            if (w_cap)
                r_to <= '0;
            else if (!w_tmo)
                r_to <= r_to + TO_ONE;
            r_vv <= w_pub;
            if (w_pub) begin
                r_value <= r_slot;
                r_err   <= w_any_err;
            end
        end
    end

    assign value       = r_value;
    assign value_valid = r_vv;
    assign digit_err   = r_err;
    assign blank       = w_tmo;
endmodule
